// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: merges core hold/flush requests into one hold level and rations rib bus ownership
// Ports: clk; rst (active-low, async); jump_flag_i/jump_addr_i redirect from ex;
//   hold_flag_ex_i, hold_flag_clint_i, jtag_halt_i hold sources; hold_flag_rib_i external
//   bus request; rib_grant_o bus grant; hold_flag_o 0 none/1 pc/2 if/3 id;
//   jump_flag_o/jump_addr_o redirect to pc_reg; stall_cnt_o saturating held-cycle count.
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int RIB_MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_clint_i,
  input  logic        jtag_halt_i,
  input  logic        hold_flag_rib_i,
  output logic        rib_grant_o,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [31:0] stall_cnt_o
);
  typedef enum logic [1:0] {RUN, FLUSH, RIB, RIB_DEFER} state_t;
  state_t state, state_nxt;
  logic [2:0]  flush_cnt, flush_cnt_nxt;
  logic [31:0] rib_cnt, rib_cnt_nxt;
  logic [31:0] stall_cnt;
  logic        hold_id;
  always_comb begin
    hold_id     = rst & (jump_flag_i | state == FLUSH | hold_flag_ex_i | hold_flag_clint_i);
    rib_grant_o = rst & hold_flag_rib_i & ~hold_id & ~jtag_halt_i & state != RIB_DEFER
                  & rib_cnt < 32'(RIB_MAX_HOLD);
    hold_flag_o = hold_id ? 3'd3 : ((rst & jtag_halt_i) | rib_grant_o) ? 3'd1 : 3'd0;
    jump_flag_o = rst & jump_flag_i;
    jump_addr_o = jump_flag_o ? jump_addr_i : 32'h0;
    state_nxt     = RUN;
    flush_cnt_nxt = '0;
    rib_cnt_nxt   = '0;
    // jump beats everything; an ungranted rib cycle always falls back to RUN
    if (jump_flag_i) begin
      state_nxt     = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      flush_cnt_nxt = 3'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH && flush_cnt > 3'd1) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = flush_cnt - 3'd1;
    end else if (rib_grant_o) begin
      rib_cnt_nxt = rib_cnt + 32'd1;
      state_nxt   = rib_cnt_nxt >= 32'(RIB_MAX_HOLD) ? RIB_DEFER : RIB;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      rib_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      rib_cnt   <= rib_cnt_nxt;
      if (hold_flag_o != 3'd0 && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
  assign stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb_pipe_hold_ctrl: scoreboard bench for pipe_hold_ctrl with FLUSH_CYCLES=3, RIB_MAX_HOLD=4
module tb_pipe_hold_ctrl;
  logic        clk = 0, rst = 0;
  logic        jump_flag_i = 0, hold_flag_ex_i = 0, hold_flag_clint_i = 0;
  logic        jtag_halt_i = 0, hold_flag_rib_i = 0;
  logic [31:0] jump_addr_i = 0;
  logic        rib_grant_o, jump_flag_o;
  logic [2:0]  hold_flag_o;
  logic [31:0] jump_addr_o, stall_cnt_o;
  int checks = 0, failures = 0;
  logic [31:0] exp_stall = 0;
  typedef struct {logic [2:0] hold; logic grant; logic jf; logic [31:0] ja;} exp_t;
  exp_t exp_q[$];
  pipe_hold_ctrl #(.FLUSH_CYCLES(3), .RIB_MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_clint_i(hold_flag_clint_i),
    .jtag_halt_i(jtag_halt_i), .hold_flag_rib_i(hold_flag_rib_i),
    .rib_grant_o(rib_grant_o), .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o),
    .jump_addr_o(jump_addr_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic j, input logic [31:0] a, input logic ex, input logic cl,
                     input logic jt, input logic rb, input logic [2:0] eh, input logic eg);
    exp_t e;
    @(posedge clk); #1;
    jump_flag_i = j; jump_addr_i = a; hold_flag_ex_i = ex; hold_flag_clint_i = cl;
    jtag_halt_i = jt; hold_flag_rib_i = rb;
    exp_q.push_back('{eh, eg, j, j ? a : 32'h0});
    @(negedge clk);
    e = exp_q.pop_front();
    check("hold", 32'(hold_flag_o), 32'(e.hold));
    check("grant", 32'(rib_grant_o), 32'(e.grant));
    check("jflag", 32'(jump_flag_o), 32'(e.jf));
    check("jaddr", jump_addr_o, e.ja);
    check("stall", stall_cnt_o, exp_stall);
    if (eh != 3'd0 && exp_stall != 32'hFFFF_FFFF) exp_stall++;
  endtask
  task automatic idle(input logic [2:0] eh);
    cyc(0, 32'h0, 0, 0, 0, 0, eh, 0);
  endtask
  task automatic rib(input logic eg);
    cyc(0, 32'h0, 0, 0, 0, 1, eg ? 3'd1 : 3'd0, eg);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    jump_flag_i = 1; jump_addr_i = 32'h55; hold_flag_rib_i = 1; hold_flag_ex_i = 1;
    #3;
    check("rst_hold", 32'(hold_flag_o), 0);
    check("rst_grant", 32'(rib_grant_o), 0);
    check("rst_jflag", 32'(jump_flag_o), 0);
    check("rst_jaddr", jump_addr_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    jump_flag_i = 0; jump_addr_i = 0; hold_flag_rib_i = 0; hold_flag_ex_i = 0;
    @(posedge clk); #1 rst = 1;
    for (int i = 0; i < 3; i++) idle(0);
    // single jump: three Hold_Id cycles
    cyc(1, 32'h100, 0, 0, 0, 0, 3, 0);
    idle(3); idle(3); idle(0); idle(0);
    check("stall_jump", stall_cnt_o, 32'd3);
    // second jump inside FLUSH reloads the window
    cyc(1, 32'h200, 0, 0, 0, 0, 3, 0);
    idle(3);
    cyc(1, 32'h300, 0, 0, 0, 0, 3, 0);
    idle(3); idle(3); idle(0);
    // rib rationing: 1111 0 1111 0 11
    for (int i = 0; i < 12; i++) rib(!(i == 4 || i == 9));
    idle(0);
    // ex hold preempts grant, regrant restarts the budget
    rib(1);
    cyc(0, 32'h0, 1, 0, 0, 1, 3, 0);
    for (int i = 0; i < 5; i++) rib(i < 4);
    idle(0);
    // clint hold blocks grant
    cyc(0, 32'h0, 0, 1, 0, 1, 3, 0);
    idle(0);
    // jump beats rib mid-grant
    rib(1);
    cyc(1, 32'h400, 0, 0, 0, 1, 3, 0);
    cyc(0, 32'h0, 0, 0, 0, 1, 3, 0);
    cyc(0, 32'h0, 0, 0, 0, 1, 3, 0);
    rib(1);
    idle(0);
    // jtag halt with rib request, and mid-grant halt
    cyc(0, 32'h0, 0, 0, 1, 1, 1, 0);
    cyc(0, 32'h0, 0, 0, 1, 1, 1, 0);
    idle(0);
    rib(1);
    cyc(0, 32'h0, 0, 0, 1, 1, 1, 0);
    rib(1);
    idle(0);
    idle(0);
    // stall counter saturation
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt;
    exp_stall = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0, 0, 0, 3, 0);
    idle(0);
    check("stall_sat", stall_cnt_o, 32'hFFFF_FFFF);
    // async reset mid-RIB
    rib(1);
    @(posedge clk); #2 rst = 0;
    #1;
    check("rstmid_grant", 32'(rib_grant_o), 0);
    check("rstmid_hold", 32'(hold_flag_o), 0);
    check("rstmid_stall", stall_cnt_o, 0);
    exp_stall = 0;
    hold_flag_rib_i = 0;
    @(negedge clk) rst = 1;
    for (int i = 0; i < 5; i++) rib(i < 4);
    idle(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
